// File: rtl/if_id_pkg.sv
// Shared fetch-path constants and types for the IF/ID pipeline register slice.
package if_id_pkg;

    localparam logic RstEnable  = 1'b1;
    localparam logic ChipEnable = 1'b1;
    localparam logic Stop       = 1'b1;
    localparam logic NoStop     = 1'b0;

    localparam int unsigned InstAddrBus = 32;
    localparam int unsigned InstBus     = 32;

    localparam logic [31:0] ZeroWord = '0;

    // Source of the next id_* value.
    typedef enum logic [1:0] {
        SEL_BUBBLE,
        SEL_HOLD,
        SEL_SKID,
        SEL_RET
    } out_sel_e;

    // Action on the one-entry skid buffer.
    typedef enum logic [1:0] {
        SKID_IDLE,
        SKID_CAPTURE,
        SKID_LOAD,
        SKID_RELEASE
    } skid_op_e;

    typedef struct packed {
        logic [InstAddrBus-1:0] pc;
        logic [InstBus-1:0]     inst;
    } fetch_t;

    function automatic fetch_t bubble();
        fetch_t f;
        f.pc   = ZeroWord;
        f.inst = ZeroWord;
        return f;
    endfunction

endpackage

// File: rtl/if_skid_buf.sv
// One-entry holding register for a fetch return that ID cannot accept yet.
module if_skid_buf
    import if_id_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   capture,
    input  logic                   release_buf,
    input  logic                   load,
    input  logic [InstAddrBus-1:0] ret_pc,
    input  logic [InstBus-1:0]     ret_inst,
    output logic                   valid,
    output logic [InstAddrBus-1:0] pc,
    output logic [InstBus-1:0]     inst
);

    // capture fills only an empty entry; load replaces whatever is held.
    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            valid <= 1'b0;
            pc    <= ZeroWord;
            inst  <= ZeroWord;
        end else if ((capture && !valid) || load) begin
            valid <= 1'b1;
            pc    <= ret_pc;
            inst  <= ret_inst;
        end else if (release_buf) begin
            valid <= 1'b0;
            pc    <= ZeroWord;
            inst  <= ZeroWord;
        end
    end

endmodule

// File: rtl/if_id.sv
// IF/ID stage register: tracks the 1-cycle instruction-memory request and
// presents fetched instructions to ID, parking a return in a skid entry on stall.
module if_id
    import if_id_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic [5:0]             stall,
    input  logic                   flush,
    input  logic                   if_ce,
    input  logic [InstAddrBus-1:0] if_pc,
    input  logic [InstBus-1:0]     if_inst,
    output logic [InstAddrBus-1:0] id_pc,
    output logic [InstBus-1:0]     id_inst,
    output logic                   id_valid
);

    logic                   req_valid;
    logic [InstAddrBus-1:0] req_pc;
    logic                   ret_valid;
    fetch_t                 ret;

    logic                   skid_valid;
    logic [InstAddrBus-1:0] skid_pc;
    logic [InstBus-1:0]     skid_inst;
    logic                   skid_capture;
    logic                   skid_release;
    logic                   skid_load;

    out_sel_e               out_sel;
    skid_op_e               skid_op;

    logic                   unused_stall_hi;
    assign unused_stall_hi = &{1'b0, stall[5:3]};

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            req_valid <= 1'b0;
            req_pc    <= ZeroWord;
        end else begin
            req_valid <= (if_ce == ChipEnable) && (stall[0] == NoStop) && !flush;
            req_pc    <= if_pc;
        end
    end

    assign ret_valid = req_valid;
    assign ret.pc    = req_pc;
    assign ret.inst  = if_inst;

    always_comb begin
        out_sel = SEL_BUBBLE;
        skid_op = SKID_IDLE;
        if (flush) begin
            skid_op = SKID_RELEASE;
        end else if (stall[1] == Stop) begin
            out_sel = (stall[2] == Stop) ? SEL_HOLD : SEL_BUBBLE;
            if (ret_valid && !skid_valid) begin
                skid_op = SKID_CAPTURE;
            end
        end else if (skid_valid) begin
            // Drain the skid first to keep program order; the new return takes its slot.
            out_sel = SEL_SKID;
            skid_op = ret_valid ? SKID_LOAD : SKID_RELEASE;
        end else if (ret_valid) begin
            out_sel = SEL_RET;
        end
    end

    assign skid_capture = (skid_op == SKID_CAPTURE);
    assign skid_load    = (skid_op == SKID_LOAD);
    assign skid_release = (skid_op == SKID_RELEASE);

    if_skid_buf u_skid (
        .clk         (clk),
        .rst         (rst),
        .capture     (skid_capture),
        .release_buf (skid_release),
        .load        (skid_load),
        .ret_pc      (ret.pc),
        .ret_inst    (ret.inst),
        .valid       (skid_valid),
        .pc          (skid_pc),
        .inst        (skid_inst)
    );

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            id_pc    <= ZeroWord;
            id_inst  <= ZeroWord;
            id_valid <= 1'b0;
        end else begin
            case (out_sel)
                SEL_HOLD: begin
                    id_pc    <= id_pc;
                    id_inst  <= id_inst;
                    id_valid <= id_valid;
                end
                SEL_SKID: begin
                    id_pc    <= skid_pc;
                    id_inst  <= skid_inst;
                    id_valid <= 1'b1;
                end
                SEL_RET: begin
                    id_pc    <= ret.pc;
                    id_inst  <= ret.inst;
                    id_valid <= 1'b1;
                end
                default: begin
                    id_pc    <= bubble().pc;
                    id_inst  <= bubble().inst;
                    id_valid <= 1'b0;
                end
            endcase
        end
    end

    // A second return while the skid is occupied and IF is stalled would be lost.
    a_no_skid_overrun: assert property (@(posedge clk) disable iff (rst == RstEnable)
        !(ret_valid && skid_valid && (stall[1] == Stop) && !flush))
        else $error("if_id: return arrived while skid buffer full and IF stalled");

endmodule

// File: tb/tb_if_id.sv
// Directed bench for if_id with a scoreboard of expected fetches in program order.
module tb_if_id;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall;
    logic        flush;
    logic        if_ce;
    logic [31:0] if_pc;
    logic [31:0] if_inst = '0;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic        id_valid;

    int n_cmp = 0;
    int n_err = 0;
    int n_valid_idle = 0;

    logic [63:0] exp_q[$];
    logic [63:0] last_seen = '0;
    logic        held = 1'b0;

    if_id dut (
        .clk      (clk),
        .rst      (rst),
        .stall    (stall),
        .flush    (flush),
        .if_ce    (if_ce),
        .if_pc    (if_pc),
        .if_inst  (if_inst),
        .id_pc    (id_pc),
        .id_inst  (id_inst),
        .id_valid (id_valid)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rom(input logic [31:0] pc);
        return 32'hA0 + pc;
    endfunction

    // Synchronous ROM: data for this cycle's address appears next cycle.
    always @(posedge clk) begin
        if (if_ce) if_inst <= rom(if_pc);
    end

    // ID held its value across this edge iff both IF and ID were stalled.
    always @(posedge clk) begin
        held <= !rst && stall[1] && stall[2] && !flush;
    end

    always @(negedge clk) begin
        if (id_valid === 1'b1) begin
            if (held) begin
                n_cmp++;
                assert ({id_pc, id_inst} === last_seen) else begin
                    n_err++;
                    $error("FAIL hold got %h/%h want %h/%h", id_pc, id_inst,
                           last_seen[63:32], last_seen[31:0]);
                end
            end else begin
                n_cmp++;
                assert (exp_q.size() != 0) else begin
                    n_err++;
                    $error("FAIL sb_extra got %h/%h want none", id_pc, id_inst);
                end
                if (exp_q.size() != 0) begin
                    last_seen = exp_q.pop_front();
                    n_cmp++;
                    assert ({id_pc, id_inst} === last_seen) else begin
                        n_err++;
                        $error("FAIL sb_order got %h/%h want %h/%h", id_pc, id_inst,
                               last_seen[63:32], last_seen[31:0]);
                    end
                end
            end
        end
    end

    task automatic step(input logic ce, input logic [31:0] pc, input logic [5:0] st,
                        input logic fl, input logic push);
        if_ce = ce;
        if_pc = pc;
        stall = st;
        flush = fl;
        if (push) exp_q.push_back({pc, rom(pc)});
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] pc_e,
                       input logic [31:0] inst_e, input logic v_e);
        n_cmp++;
        assert (id_pc === pc_e) else begin
            n_err++;
            $error("FAIL %s id_pc got %h want %h", tag, id_pc, pc_e);
        end
        n_cmp++;
        assert (id_inst === inst_e) else begin
            n_err++;
            $error("FAIL %s id_inst got %h want %h", tag, id_inst, inst_e);
        end
        n_cmp++;
        assert (id_valid === v_e) else begin
            n_err++;
            $error("FAIL %s id_valid got %b want %b", tag, id_valid, v_e);
        end
    endtask

    task automatic chk_bit(input string tag, input logic got, input logic want);
        n_cmp++;
        assert (got === want) else begin
            n_err++;
            $error("FAIL %s got %b want %b", tag, got, want);
        end
    endtask

    initial begin
        rst = 1'b1;
        step(1'b0, 32'h0, 6'b000000, 1'b0, 1'b0);
        chk("reset", 32'h0, 32'h0, 1'b0);
        step(1'b0, 32'h0, 6'b000000, 1'b0, 1'b0);
        chk_bit("reset_skid", dut.skid_valid, 1'b0);
        rst = 1'b0;

        // Straight fetch
        step(1'b1, 32'h0, 6'b000000, 1'b0, 1'b1);
        chk("lat_bubble", 32'h0, 32'h0, 1'b0);
        step(1'b1, 32'h4, 6'b000000, 1'b0, 1'b1);
        chk("fetch0", 32'h0, 32'hA0, 1'b1);
        step(1'b1, 32'h8, 6'b000000, 1'b0, 1'b1);
        chk("fetch4", 32'h4, 32'hA4, 1'b1);

        // Load-use stall: 0x8 parks in the skid while 0x4 is held
        step(1'b1, 32'hC, 6'b000111, 1'b0, 1'b0);
        chk("lu_hold", 32'h4, 32'hA4, 1'b1);
        chk_bit("lu_skid_full", dut.skid_valid, 1'b1);
        step(1'b1, 32'hC, 6'b000000, 1'b0, 1'b1);
        chk("lu_skid_out", 32'h8, 32'hA8, 1'b1);
        chk_bit("lu_skid_empty", dut.skid_valid, 1'b0);
        step(1'b1, 32'h10, 6'b000000, 1'b0, 1'b1);
        chk("lu_next", 32'hC, 32'hAC, 1'b1);

        // Bubble insertion for two cycles
        step(1'b1, 32'h14, 6'b000011, 1'b0, 1'b0);
        chk("bub1", 32'h0, 32'h0, 1'b0);
        step(1'b1, 32'h14, 6'b000011, 1'b0, 1'b0);
        chk("bub2", 32'h0, 32'h0, 1'b0);
        step(1'b1, 32'h14, 6'b000000, 1'b0, 1'b1);
        chk("bub_resume", 32'h10, 32'hB0, 1'b1);
        step(1'b0, 32'h18, 6'b000000, 1'b0, 1'b0);
        chk("bub_next", 32'h14, 32'hB4, 1'b1);

        // Flush with skid full and a return in flight
        step(1'b1, 32'h18, 6'b000000, 1'b0, 1'b0);
        chk("fl_pre", 32'h0, 32'h0, 1'b0);
        step(1'b1, 32'h1C, 6'b000110, 1'b0, 1'b0);
        chk_bit("fl_skid_full", dut.skid_valid, 1'b1);
        step(1'b1, 32'h1C, 6'b000111, 1'b1, 1'b0);
        chk("fl_bubble", 32'h0, 32'h0, 1'b0);
        chk_bit("fl_skid_clear", dut.skid_valid, 1'b0);
        step(1'b1, 32'h20, 6'b000000, 1'b0, 1'b1);
        chk("fl_no_inflight", 32'h0, 32'h0, 1'b0);
        step(1'b0, 32'h24, 6'b000000, 1'b0, 1'b0);
        chk("fl_restart", 32'h20, 32'hC0, 1'b1);
        step(1'b0, 32'h24, 6'b000000, 1'b0, 1'b0);
        chk("fl_idle", 32'h0, 32'h0, 1'b0);

        // Reset while the skid holds an entry
        step(1'b1, 32'h28, 6'b000000, 1'b0, 1'b0);
        step(1'b1, 32'h2C, 6'b000111, 1'b0, 1'b0);
        chk_bit("rs_skid_full", dut.skid_valid, 1'b1);
        rst = 1'b1;
        step(1'b1, 32'h2C, 6'b000000, 1'b0, 1'b0);
        chk("rs_zero", 32'h0, 32'h0, 1'b0);
        chk_bit("rs_skid_clear", dut.skid_valid, 1'b0);
        rst = 1'b0;
        step(1'b1, 32'h0, 6'b000000, 1'b0, 1'b1);
        chk("rs_no_inflight", 32'h0, 32'h0, 1'b0);

        // Idle: if_ce low for 5 cycles after one fetch
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 32'h4, 6'b000000, 1'b0, 1'b0);
            if (id_valid === 1'b1) n_valid_idle++;
            if (i == 0) chk("idle_first", 32'h0, 32'hA0, 1'b1);
            else        chk("idle_bubble", 32'h0, 32'h0, 1'b0);
        end
        n_cmp++;
        assert (n_valid_idle == 1) else begin
            n_err++;
            $error("FAIL idle_count got %0d want 1", n_valid_idle);
        end

        @(negedge clk);
        n_cmp++;
        assert (exp_q.size() == 0) else begin
            n_err++;
            $error("FAIL sb_drain got %0d left want 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/if_id.md
IF_ID -- requirements
Module: if_id

Interface
REQ-001 Parameters: none; all widths come from the shared defines (InstAddrBus = 32 bits, InstBus = 32 bits).
REQ-002 Clock and reset: one clock; reset is synchronous and active-high. Ports are clk and rst.
REQ-003 clk  in  1  sole clock; all state updates on the rising edge.
REQ-004 rst  in  1  synchronous, active-high reset (RstEnable).
REQ-005 stall  in  6  stall vector from ctrl; bit0 = PC, bit1 = IF, bit2 = ID; Stop = 1.
REQ-006 flush  in  1  discard all in-flight and held fetch state.
REQ-007 if_ce  in  1  fetch enable from the PC stage; the instruction memory reads only when it is high.
REQ-008 if_pc  in  32  fetch address presented to the instruction memory this cycle.
REQ-009 if_inst  in  32  instruction memory read data; 1-cycle latency, so it belongs to the previous cycle's if_pc.
REQ-010 id_pc  out  32  PC of the instruction presented to ID.
REQ-011 id_inst  out  32  instruction presented to ID; 0 (nop) when not valid.
REQ-012 id_valid  out  1  id_pc/id_inst hold a real fetched instruction.

Function
REQ-013 Request tracking: each cycle, register req_valid <= if_ce & ~stall[0] & ~flush, and req_pc <= if_pc.
REQ-014 Return: in a cycle with req_valid = 1, the pair (req_pc, if_inst) is a valid return ("ret").
REQ-015 The block has a one-entry skid buffer (skid_valid, skid_pc, skid_inst) that holds a return which ID cannot accept yet.
REQ-016 Bubble definition: id_pc = 0, id_inst = 0, id_valid = 0.
REQ-017 Priority per cycle: rst > flush > stall rules (REQ-018 to REQ-021).
REQ-018 flush = 1: outputs become a bubble next cycle; skid_valid <= 0; req_valid <= 0; the current ret is discarded.
REQ-019 stall[1] = Stop and stall[2] = NoStop: outputs become a bubble next cycle.
REQ-020 stall[1] = Stop and stall[2] = Stop: outputs hold their current values.
REQ-021 In both stall cases (REQ-019, REQ-020), if ret is valid and skid_valid = 0, ret is captured into the skid buffer.
REQ-022 stall[1] = NoStop, skid_valid = 1: outputs <= skid contents, id_valid = 1; then skid <= ret if ret is valid, else skid_valid <= 0.
REQ-023 stall[1] = NoStop, skid_valid = 0: outputs <= ret if ret is valid, else a bubble.
REQ-024 Program order is preserved: no instruction is dropped, duplicated or reordered unless flush is asserted.
REQ-025 Latency: an instruction whose PC is issued in cycle N with no stall reaches id_* at the end of cycle N+1, i.e. it is visible in cycle N+2.
REQ-026 A ret arriving while skid_valid = 1 and stall[1] = Stop is a protocol violation (ctrl stalls bit0 together with bit1); the design asserts on it in simulation and the bench checks it never fires.
REQ-027 When if_ce = 0, no request is registered, and the block emits bubbles once the skid buffer and the in-flight return have drained.

Reset
REQ-028 When rst = 1 at a clock edge, the following all become 0 at that edge: id_pc, id_inst, id_valid, req_valid, req_pc, skid_valid, skid_pc, skid_inst.
REQ-029 A reset in mid-operation discards any skid buffer contents and any in-flight return; the first valid output after reset comes from a request issued after rst deasserts.

Structure
REQ-030 The following constants live in the shared defines and are not redefined locally: RstEnable, Stop, NoStop, ZeroWord, InstAddrBus, InstBus, ChipEnable.
REQ-031 The skid entry is a sub-module if_skid_buf with inputs capture, release, load, pc and inst, and outputs valid, pc and inst; the request tracker and output register stay in if_id.

Verification
REQ-032 Straight fetch: rst for 2 cycles, then if_ce = 1 with if_pc = 0x0, 0x4, 0x8 and ROM data 0xA0, 0xA4, 0xA8 -> id_pc/id_inst = 0x0/0xA0, 0x4/0xA4, 0x8/0xA8 in consecutive cycles starting 2 cycles after 0x0 is issued.
REQ-033 Load-use stall: stall = 6'b000111 for 1 cycle while 0x4 is in ID and 0x8 is returning -> 0x8 is captured in the skid buffer; id_* holds 0x4; after release, 0x8 then 0xC follow with none lost and none duplicated.
REQ-034 Bubble insertion: stall = 6'b000011 for 2 cycles -> id_valid = 0 and id_inst = 0 for both cycles, then resume with the correct next PC.
REQ-035 Flush: flush = 1 in the same cycle as stall = 6'b000111 with the skid buffer full -> next cycle is a bubble, skid_valid = 0, and the ROM data in flight is not presented.
REQ-036 Reset mid-stream: rst = 1 while skid_valid = 1 -> all outputs are 0 the following cycle, and the first id_valid = 1 is for PC 0x0.
REQ-037 Idle: if_ce = 0 for 5 cycles after one valid fetch -> exactly one valid instruction is emitted, followed by continuous bubbles.
